// File: rtl/range_window_detector_if.sv
// Sample/threshold inputs and debounced zone outputs of the range window detector.
// sample_valid qualifies sample_data for exactly one cycle; there is no backpressure.
interface range_window_detector_if #(
    parameter int SAMPLE_W = 12
);
    logic [7:0]          range1;
    logic [7:0]          range2;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_data;
    logic                clr_count;
    logic [1:0]          zone;
    logic                zone_change;
    logic                alarm;
    logic [15:0]         event_count;
    logic [1:0]          dbg_candidate;
    logic [3:0]          dbg_run_count;

    modport master (
        output range1, range2, sample_valid, sample_data, clr_count,
        input  zone, zone_change, alarm, event_count, dbg_candidate, dbg_run_count
    );

    modport slave (
        input  range1, range2, sample_valid, sample_data, clr_count,
        output zone, zone_change, alarm, event_count, dbg_candidate, dbg_run_count
    );
endinterface

// File: rtl/range_window_detector.sv
// Debounced classification of ADC samples into BELOW / INSIDE / ABOVE a programmable
// window, with a registered alarm and a saturating count of zone transitions.
module range_window_detector #(
    parameter int SAMPLE_W = 12,
    parameter int DEBOUNCE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    range_window_detector_if.slave  bus
);
    typedef enum logic [1:0] {
        ZONE_UNKNOWN = 2'b00,
        ZONE_BELOW   = 2'b01,
        ZONE_INSIDE  = 2'b10,
        ZONE_ABOVE   = 2'b11
    } zone_t;

    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    zone_t       r_zone;
    zone_t       w_zone_next;
    zone_t       r_cand;
    zone_t       w_cand_next;
    zone_t       w_raw;
    logic [3:0]  r_run;
    logic [3:0]  w_run_next;
    logic        w_update;
    logic        r_zone_change;
    logic        r_alarm;
    logic [15:0] r_event_count;
    logic [15:0] w_count_next;
    logic [7:0]  w_s8;
    logic [7:0]  w_lo;
    logic [7:0]  w_hi;

    // Only the top byte of the conversion is compared against the thresholds.
    assign w_s8 = bus.sample_data[SAMPLE_W-1 -: 8];
    assign w_lo = (bus.range1 < bus.range2) ? bus.range1 : bus.range2;
    assign w_hi = (bus.range1 < bus.range2) ? bus.range2 : bus.range1;

    always_comb begin
        w_raw = ZONE_INSIDE;
        if (w_s8 < w_lo) begin
            w_raw = ZONE_BELOW;
        end else if (w_s8 > w_hi) begin
            w_raw = ZONE_ABOVE;
        end
    end

    always_comb begin
        w_cand_next  = r_cand;
        w_run_next   = r_run;
        w_zone_next  = r_zone;
        w_update     = 1'b0;
        w_count_next = r_event_count;
        if (bus.sample_valid) begin
            if (w_raw != r_cand) begin
                w_cand_next = w_raw;
                w_run_next  = 4'd1;
            end else if (r_run < DEB) begin
                w_run_next = r_run + 4'd1;
            end
            // A run that lands back on the current zone simply re-arms the candidate.
            if (w_run_next == DEB && w_cand_next != r_zone) begin
                w_zone_next = w_cand_next;
                w_update    = 1'b1;
            end
        end
        if (bus.clr_count) begin
            w_count_next = 16'd0;
        end else if (w_update && r_zone != ZONE_UNKNOWN && r_event_count != 16'hFFFF) begin
            w_count_next = r_event_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_zone        <= ZONE_UNKNOWN;
            r_cand        <= ZONE_UNKNOWN;
            r_run         <= 4'd0;
            r_zone_change <= 1'b0;
            r_alarm       <= 1'b0;
            r_event_count <= 16'd0;
        end else begin
            r_zone        <= w_zone_next;
            r_cand        <= w_cand_next;
            r_run         <= w_run_next;
            r_zone_change <= w_update;
            r_alarm       <= (w_zone_next == ZONE_BELOW) || (w_zone_next == ZONE_ABOVE);
            r_event_count <= w_count_next;
        end
    end

    assign bus.zone          = r_zone;
    assign bus.zone_change   = r_zone_change;
    assign bus.alarm         = r_alarm;
    assign bus.event_count   = r_event_count;
    assign bus.dbg_candidate = r_cand;
    assign bus.dbg_run_count = r_run;
endmodule

// File: tb/tb_range_window_detector.sv
// Bench for range_window_detector: a DEBOUNCE=4 and a DEBOUNCE=1 instance driven in lockstep,
// checked by directed scenarios and by random traffic against a sample-history model.
module tb_range_window_detector;
    localparam int SW   = 12;
    localparam int DEB0 = 4;
    localparam int DEB1 = 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    range_window_detector_if #(.SAMPLE_W(SW)) bus0 ();
    range_window_detector_if #(.SAMPLE_W(SW)) bus1 ();

    range_window_detector #(.SAMPLE_W(SW), .DEBOUNCE(DEB0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    range_window_detector #(.SAMPLE_W(SW), .DEBOUNCE(DEB1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the zone follows the longest trailing run of identical regions in the sample history.
    int         hist[$];
    int         m_zone[2];
    int         m_change[2];
    int         m_count[2];
    logic [7:0] cur_r1;
    logic [7:0] cur_r2;

    function automatic int region_of(input logic [SW-1:0] data, input logic [7:0] r1, input logic [7:0] r2);
        int s8, lo, hi;
        s8 = int'(data) >> (SW - 8);
        lo = (int'(r1) < int'(r2)) ? int'(r1) : int'(r2);
        hi = (int'(r1) < int'(r2)) ? int'(r2) : int'(r1);
        if (s8 < lo) return 1;
        if (s8 > hi) return 3;
        return 2;
    endfunction

    task automatic model_step(input logic rst, input logic vld, input logic [SW-1:0] data,
                              input logic [7:0] r1, input logic [7:0] r2, input logic clr);
        int rg, streak, deb;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < 2; k++) begin
                m_zone[k] = 0; m_change[k] = 0; m_count[k] = 0;
            end
            return;
        end
        for (int k = 0; k < 2; k++) m_change[k] = 0;
        if (vld) begin
            rg = region_of(data, r1, r2);
            hist.push_back(rg);
            if (hist.size() > 40) void'(hist.pop_front());
            streak = 0;
            for (int j = hist.size() - 1; j >= 0; j--) begin
                if (hist[j] != rg) break;
                streak++;
            end
            for (int k = 0; k < 2; k++) begin
                deb = (k == 0) ? DEB0 : DEB1;
                if (streak >= deb && rg != m_zone[k]) begin
                    if (m_zone[k] != 0 && m_count[k] != 65535) m_count[k]++;
                    m_zone[k]   = rg;
                    m_change[k] = 1;
                end
            end
        end
        if (clr) for (int k = 0; k < 2; k++) m_count[k] = 0;
    endtask

    task automatic tick(input logic rst, input logic vld, input logic [SW-1:0] data,
                        input logic [7:0] r1, input logic [7:0] r2, input logic clr);
        reset             = rst;
        bus0.sample_valid = vld;  bus1.sample_valid = vld;
        bus0.sample_data  = data; bus1.sample_data  = data;
        bus0.range1       = r1;   bus1.range1       = r1;
        bus0.range2       = r2;   bus1.range2       = r2;
        bus0.clr_count    = clr;  bus1.clr_count    = clr;
        model_step(rst, vld, data, r1, r2, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [SW-1:0] data);
        tick(1'b0, 1'b1, data, cur_r1, cur_r2, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 12'hF00, 8'h40, 8'hC0, 1'b1);
        tick(1'b1, 1'b1, 12'hF00, 8'h40, 8'hC0, 1'b1);
        n_checks += 6;
        if (bus0.zone !== 2'b00) begin n_errors++; $display("FAIL reset_zone: got %b expected 00", bus0.zone); end
        if (bus0.zone_change !== 1'b0) begin n_errors++; $display("FAIL reset_change: got %b expected 0", bus0.zone_change); end
        if (bus0.alarm !== 1'b0) begin n_errors++; $display("FAIL reset_alarm: got %b expected 0", bus0.alarm); end
        if (bus0.event_count !== 16'h0) begin n_errors++; $display("FAIL reset_count: got %h expected 0000", bus0.event_count); end
        if (bus0.dbg_candidate !== 2'b00) begin n_errors++; $display("FAIL reset_cand: got %b expected 00", bus0.dbg_candidate); end
        if (bus0.dbg_run_count !== 4'd0) begin n_errors++; $display("FAIL reset_run: got %0d expected 0", bus0.dbg_run_count); end
    endtask

    task automatic test_inside();
        cur_r1 = 8'h40; cur_r2 = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            sample(12'h800);
            n_checks++;
            if (bus0.zone !== 2'b00) begin n_errors++; $display("FAIL inside_early_zone[%0d]: got %b expected 00", i, bus0.zone); end
        end
        sample(12'h800);
        n_checks += 4;
        if (bus0.zone !== 2'b10) begin n_errors++; $display("FAIL inside_zone: got %b expected 10", bus0.zone); end
        if (bus0.zone_change !== 1'b1) begin n_errors++; $display("FAIL inside_change: got %b expected 1", bus0.zone_change); end
        if (bus0.alarm !== 1'b0) begin n_errors++; $display("FAIL inside_alarm: got %b expected 0", bus0.alarm); end
        if (bus0.event_count !== 16'd0) begin n_errors++; $display("FAIL inside_count: got %0d expected 0", bus0.event_count); end
        tick(1'b0, 1'b0, 12'h000, cur_r1, cur_r2, 1'b0);
        n_checks++;
        if (bus0.zone_change !== 1'b0) begin n_errors++; $display("FAIL inside_pulse_width: got %b expected 0", bus0.zone_change); end
    endtask

    task automatic test_glitch();
        logic [SW-1:0] seq[8];
        seq = '{12'hF00, 12'hF00, 12'hF00, 12'h800, 12'hF00, 12'hF00, 12'hF00, 12'hF00};
        for (int i = 0; i < 7; i++) begin
            sample(seq[i]);
            n_checks += 2;
            if (bus0.zone !== 2'b10) begin n_errors++; $display("FAIL glitch_hold_zone[%0d]: got %b expected 10", i, bus0.zone); end
            if (bus0.zone_change !== 1'b0) begin n_errors++; $display("FAIL glitch_hold_change[%0d]: got %b expected 0", i, bus0.zone_change); end
        end
        sample(seq[7]);
        n_checks += 4;
        if (bus0.zone !== 2'b11) begin n_errors++; $display("FAIL glitch_zone: got %b expected 11", bus0.zone); end
        if (bus0.zone_change !== 1'b1) begin n_errors++; $display("FAIL glitch_change: got %b expected 1", bus0.zone_change); end
        if (bus0.alarm !== 1'b1) begin n_errors++; $display("FAIL glitch_alarm: got %b expected 1", bus0.alarm); end
        if (bus0.event_count !== 16'd1) begin n_errors++; $display("FAIL glitch_count: got %0d expected 1", bus0.event_count); end
    endtask

    task automatic test_swapped();
        cur_r1 = 8'hC0; cur_r2 = 8'h40;
        for (int i = 0; i < 4; i++) sample(12'h400);
        n_checks += 2;
        if (bus0.zone !== 2'b10) begin n_errors++; $display("FAIL swap_lo_edge_zone: got %b expected 10", bus0.zone); end
        if (bus0.alarm !== 1'b0) begin n_errors++; $display("FAIL swap_lo_edge_alarm: got %b expected 0", bus0.alarm); end
        for (int i = 0; i < 4; i++) begin
            sample(12'hC00);
            n_checks++;
            if (bus0.zone !== 2'b10) begin n_errors++; $display("FAIL swap_hi_edge_zone[%0d]: got %b expected 10", i, bus0.zone); end
        end
        for (int i = 0; i < 3; i++) sample(12'h3F0);
        n_checks++;
        if (bus0.zone !== 2'b10) begin n_errors++; $display("FAIL swap_below_early: got %b expected 10", bus0.zone); end
        sample(12'h3F0);
        n_checks += 3;
        if (bus0.zone !== 2'b01) begin n_errors++; $display("FAIL swap_below_zone: got %b expected 01", bus0.zone); end
        if (bus0.alarm !== 1'b1) begin n_errors++; $display("FAIL swap_below_alarm: got %b expected 1", bus0.alarm); end
        if (bus0.event_count !== 16'd3) begin n_errors++; $display("FAIL swap_count: got %0d expected 3", bus0.event_count); end
    endtask

    task automatic test_clr();
        cur_r1 = 8'h40; cur_r2 = 8'hC0;
        for (int i = 0; i < 3; i++) sample(12'h800);
        tick(1'b0, 1'b1, 12'h800, cur_r1, cur_r2, 1'b1);
        n_checks += 3;
        if (bus0.zone !== 2'b10) begin n_errors++; $display("FAIL clr_zone: got %b expected 10", bus0.zone); end
        if (bus0.zone_change !== 1'b1) begin n_errors++; $display("FAIL clr_change: got %b expected 1", bus0.zone_change); end
        if (bus0.event_count !== 16'd0) begin n_errors++; $display("FAIL clr_count: got %0d expected 0", bus0.event_count); end
    endtask

    task automatic test_reset_mid();
        cur_r1 = 8'h40; cur_r2 = 8'hC0;
        tick(1'b1, 1'b0, 12'h000, cur_r1, cur_r2, 1'b0);
        sample(12'hF00);
        sample(12'hF00);
        tick(1'b1, 1'b1, 12'hF00, cur_r1, cur_r2, 1'b0);
        n_checks += 2;
        if (bus0.zone !== 2'b00) begin n_errors++; $display("FAIL rstmid_zone: got %b expected 00", bus0.zone); end
        if (bus0.dbg_run_count !== 4'd0) begin n_errors++; $display("FAIL rstmid_run: got %0d expected 0", bus0.dbg_run_count); end
        for (int i = 0; i < 3; i++) begin
            sample(12'hF00);
            n_checks++;
            if (bus0.zone !== 2'b00) begin n_errors++; $display("FAIL rstmid_hold[%0d]: got %b expected 00", i, bus0.zone); end
        end
        sample(12'hF00);
        n_checks += 3;
        if (bus0.zone !== 2'b11) begin n_errors++; $display("FAIL rstmid_zone_final: got %b expected 11", bus0.zone); end
        if (bus0.zone_change !== 1'b1) begin n_errors++; $display("FAIL rstmid_change: got %b expected 1", bus0.zone_change); end
        if (bus0.event_count !== 16'd0) begin n_errors++; $display("FAIL rstmid_count: got %0d expected 0", bus0.event_count); end
    endtask

    task automatic test_deb1_alternate();
        logic [1:0] exp_zone;
        cur_r1 = 8'h40; cur_r2 = 8'hC0;
        tick(1'b1, 1'b0, 12'h000, cur_r1, cur_r2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            sample((i % 2 == 0) ? 12'h100 : 12'hF00);
            exp_zone = (i % 2 == 0) ? 2'b01 : 2'b11;
            n_checks += 2;
            if (bus1.zone !== exp_zone) begin n_errors++; $display("FAIL deb1_zone[%0d]: got %b expected %b", i, bus1.zone, exp_zone); end
            if (bus1.alarm !== 1'b1) begin n_errors++; $display("FAIL deb1_alarm[%0d]: got %b expected 1", i, bus1.alarm); end
            if (i > 0) begin
                n_checks++;
                if (bus1.zone_change !== 1'b1) begin n_errors++; $display("FAIL deb1_change[%0d]: got %b expected 1", i, bus1.zone_change); end
            end
        end
        n_checks++;
        if (bus1.event_count !== 16'd7) begin n_errors++; $display("FAIL deb1_count: got %0d expected 7", bus1.event_count); end
    endtask

    task automatic test_saturation();
        cur_r1 = 8'h40; cur_r2 = 8'hC0;
        tick(1'b1, 1'b0, 12'h000, cur_r1, cur_r2, 1'b0);
        for (int i = 0; i < 65540; i++) sample((i % 2 == 0) ? 12'h100 : 12'hF00);
        n_checks += 2;
        if (bus1.event_count !== 16'hFFFF) begin n_errors++; $display("FAIL sat_count: got %h expected ffff", bus1.event_count); end
        if (bus1.zone !== 2'b11) begin n_errors++; $display("FAIL sat_zone: got %b expected 11", bus1.zone); end
        sample(12'h100);
        n_checks += 2;
        if (bus1.event_count !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold: got %h expected ffff", bus1.event_count); end
        if (bus1.zone_change !== 1'b1) begin n_errors++; $display("FAIL sat_change: got %b expected 1", bus1.zone_change); end
        tick(1'b0, 1'b1, 12'hF00, cur_r1, cur_r2, 1'b1);
        n_checks += 2;
        if (bus1.event_count !== 16'd0) begin n_errors++; $display("FAIL sat_clr: got %h expected 0000", bus1.event_count); end
        if (bus1.zone !== 2'b11) begin n_errors++; $display("FAIL sat_clr_zone: got %b expected 11", bus1.zone); end
    endtask

    task automatic test_random();
        logic          rst, vld, clr;
        logic [SW-1:0] data;
        logic [SW-1:0] levels[4];
        levels = '{12'h100, 12'h800, 12'hF00, 12'h400};
        cur_r1 = 8'h40; cur_r2 = 8'hC0;
        tick(1'b1, 1'b0, 12'h000, cur_r1, cur_r2, 1'b0);
        for (int c = 0; c < 600; c++) begin
            rst  = ($urandom_range(0, 79) == 0);
            vld  = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 31) == 0);
            data = ($urandom_range(0, 4) == 0) ? SW'($urandom_range(0, 4095)) : levels[$urandom_range(0, 3)];
            if ($urandom_range(0, 47) == 0) begin
                cur_r1 = 8'($urandom_range(0, 255));
                cur_r2 = 8'($urandom_range(0, 255));
            end
            tick(rst, vld, data, cur_r1, cur_r2, clr);
            n_checks += 8;
            if (bus0.zone !== 2'(m_zone[0])) begin n_errors++; $display("FAIL rnd_zone0 @%0d: got %b expected %0d", c, bus0.zone, m_zone[0]); end
            if (bus0.zone_change !== 1'(m_change[0])) begin n_errors++; $display("FAIL rnd_change0 @%0d: got %b expected %0d", c, bus0.zone_change, m_change[0]); end
            if (bus0.alarm !== 1'(m_zone[0] == 1 || m_zone[0] == 3)) begin n_errors++; $display("FAIL rnd_alarm0 @%0d: got %b zone %0d", c, bus0.alarm, m_zone[0]); end
            if (bus0.event_count !== 16'(m_count[0])) begin n_errors++; $display("FAIL rnd_count0 @%0d: got %0d expected %0d", c, bus0.event_count, m_count[0]); end
            if (bus1.zone !== 2'(m_zone[1])) begin n_errors++; $display("FAIL rnd_zone1 @%0d: got %b expected %0d", c, bus1.zone, m_zone[1]); end
            if (bus1.zone_change !== 1'(m_change[1])) begin n_errors++; $display("FAIL rnd_change1 @%0d: got %b expected %0d", c, bus1.zone_change, m_change[1]); end
            if (bus1.alarm !== 1'(m_zone[1] == 1 || m_zone[1] == 3)) begin n_errors++; $display("FAIL rnd_alarm1 @%0d: got %b zone %0d", c, bus1.alarm, m_zone[1]); end
            if (bus1.event_count !== 16'(m_count[1])) begin n_errors++; $display("FAIL rnd_count1 @%0d: got %0d expected %0d", c, bus1.event_count, m_count[1]); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cur_r1   = 8'h40;
        cur_r2   = 8'hC0;
        test_reset();
        test_inside();
        test_glitch();
        test_swapped();
        test_clr();
        test_reset_mid();
        test_deb1_alternate();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/range_window_detector.md
RANGE_WINDOW_DETECTOR -- requirements
Module: range_window_detector

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 12, meaning ADC sample width (8..16).
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, meaning consecutive qualifying samples needed to change zone (1..15).
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 range1  input  8  window threshold A, from the range control register.
REQ-006 range2  input  8  window threshold B, from the range control register.
REQ-007 sample_valid  input  1  one-cycle qualifier for sample_data.
REQ-008 sample_data  input  SAMPLE_W  ADC conversion result.
REQ-009 clr_count  input  1  single-cycle pulse that clears event_count.
REQ-010 zone  output  2  debounced zone: 00 UNKNOWN, 01 BELOW, 10 INSIDE, 11 ABOVE.
REQ-011 zone_change  output  1  one-cycle pulse when zone updates.
REQ-012 alarm  output  1  high while zone is BELOW or ABOVE.
REQ-013 event_count  output  16  saturating count of zone transitions out of a known zone.

Function
REQ-014 Compared value SHALL be s8 = sample_data[SAMPLE_W-1:SAMPLE_W-8] (upper 8 bits), unsigned.
REQ-015 Effective bounds SHALL be lo = min(range1, range2), hi = max(range1, range2), evaluated in the cycle sample_valid is high; range changes between samples SHALL apply only to later samples.
REQ-016 Raw region per sample: BELOW if s8 < lo; ABOVE if s8 > hi; else INSIDE (bounds inclusive; lo == hi gives a one-code window).
REQ-017 Samples are ignored whenever sample_valid is low; no counter or state changes.
REQ-018 The block SHALL hold a candidate region and a 4-bit run counter; on a valid sample whose raw region differs from the candidate, the candidate takes the new region and the run counter is set to 1.
REQ-019 On a valid sample matching the candidate, the run counter SHALL increment, saturating at DEBOUNCE.
REQ-020 When the run counter reaches DEBOUNCE (counting the current sample) and the candidate differs from zone, zone SHALL take the candidate on the next clock edge; zone_change SHALL be high for exactly that one following cycle.
REQ-021 When the candidate equals zone, zone and zone_change SHALL not change; a run in progress towards another region SHALL be discarded as soon as a sample returns to the current zone.
REQ-022 With DEBOUNCE = 1, every valid sample whose region differs from zone SHALL update zone on the next edge.
REQ-023 The zone state machine SHALL leave UNKNOWN only, never re-enter it except by reset.
REQ-024 alarm SHALL be registered and change in the same cycle as zone.
REQ-025 event_count SHALL increment by 1 on each zone update whose previous zone is not UNKNOWN, saturating at 16'hFFFF.
REQ-026 clr_count SHALL set event_count to 0 on the next edge and take priority over a simultaneous increment (result 0, the transition is not counted); zone, candidate and run counter are unaffected.

Reset
REQ-027 In the cycle after reset is sampled high: zone = 00, zone_change = 0, alarm = 0, event_count = 0, candidate = UNKNOWN, run counter = 0.
REQ-028 Reset asserted mid-debounce SHALL discard the partial run; sample_valid during reset SHALL be ignored.
REQ-029 Reset SHALL take priority over sample_valid and clr_count in the same cycle.

Verification
REQ-030 Reset, range1 = 8'h40, range2 = 8'hC0, four valid samples 12'h800 -> zone 10 one cycle after the 4th, single zone_change pulse, alarm 0, event_count 0.
REQ-031 From INSIDE, three samples 12'hF00 then one 12'h800 then four 12'hF00 -> no change until the 4th of the final run; then zone 11, alarm 1, event_count 1.
REQ-032 range1 = 8'hC0, range2 = 8'h40 (swapped), samples 12'h400 and 12'hC00 -> both INSIDE (inclusive bounds); 12'h3F0 -> BELOW after debounce.
REQ-033 clr_count pulsed in the same cycle as a counted zone update -> event_count 0, zone updated normally; event_count preloaded near 16'hFFFF by transitions -> holds at FFFF.
REQ-034 Reset asserted after 2 of 4 qualifying samples, then released -> zone 00; 4 fresh samples required before zone updates.
REQ-035 DEBOUNCE = 1 build: alternating 12'h100 / 12'hF00 samples -> zone alternates 01/11 each sample, zone_change pulses every sample after the first.
